// File: rtl/if_id_buffer_pkg.sv
// Shared definitions for the IF/ID decoupling buffer: bubble constant and the
// {pc, inst} entry type at the default widths.
package if_id_buffer_pkg;

    localparam int unsigned DefAddrW = 32;
    localparam int unsigned DefInstW = 32;

    // Value driven onto id_pc/id_inst while no valid entry is presented.
    localparam logic [31:0] ZeroWord = 32'h0000_0000;

    typedef struct packed {
        logic [DefAddrW-1:0] pc;
        logic [DefInstW-1:0] inst;
    } if_id_entry_t;

endpackage

// File: rtl/if_id_buffer_if.sv
// Handshake bundle between fetch (producer), decode (consumer) and the buffer.
// The buffer uses the slave view; the surrounding pipeline uses the master view.
interface if_id_buffer_if #(
    parameter int ADDR_W = 32,
    parameter int INST_W = 32,
    parameter int DEPTH  = 4
);
    localparam int CNT_W = $clog2(DEPTH + 1);

    logic              flush;
    logic              if_valid;
    logic              if_ready;
    logic [ADDR_W-1:0] if_pc;
    logic [INST_W-1:0] if_inst;
    logic              id_valid;
    logic              id_ready;
    logic [ADDR_W-1:0] id_pc;
    logic [INST_W-1:0] id_inst;
    logic [CNT_W-1:0]  count;

    modport master (
        output flush, if_valid, if_pc, if_inst, id_ready,
        input  if_ready, id_valid, id_pc, id_inst, count
    );

    modport slave (
        input  flush, if_valid, if_pc, if_inst, id_ready,
        output if_ready, id_valid, id_pc, id_inst, count
    );

endinterface

// File: rtl/if_id_buffer.sv
// DEPTH-entry FIFO of {pc, inst} between fetch and decode. All outputs derive
// from state only, so there is no combinational path between IF and ID.
module if_id_buffer
    import if_id_buffer_pkg::*;
#(
    parameter int ADDR_W = 32,
    parameter int INST_W = 32,
    parameter int DEPTH  = 4
) (
    input  logic          clk,
    input  logic          rst,
    if_id_buffer_if.slave bus
);

    localparam int PTR_W = $clog2(DEPTH);
    localparam int CNT_W = $clog2(DEPTH + 1);

    logic [ADDR_W-1:0] pc_mem_q   [DEPTH];
    logic [INST_W-1:0] inst_mem_q [DEPTH];

    logic [PTR_W-1:0] wr_ptr_q, wr_ptr_d;
    logic [PTR_W-1:0] rd_ptr_q, rd_ptr_d;
    logic [CNT_W-1:0] cnt_q, cnt_d;

    logic if_ready_s;
    logic id_valid_s;
    logic push_s;
    logic pop_s;

    // Handshake qualification from current occupancy.
    always_comb begin
        if_ready_s = (cnt_q != CNT_W'(DEPTH));
        id_valid_s = (cnt_q != CNT_W'(0));
        push_s     = bus.if_valid & if_ready_s;
        pop_s      = id_valid_s & bus.id_ready;
    end

    // Next-state for pointers and occupancy; flush discards any concurrent push/pop.
    always_comb begin
        wr_ptr_d = wr_ptr_q;
        rd_ptr_d = rd_ptr_q;
        cnt_d    = cnt_q;
        if (bus.flush) begin
            wr_ptr_d = PTR_W'(0);
            rd_ptr_d = PTR_W'(0);
            cnt_d    = CNT_W'(0);
        end else begin
            if (push_s) begin
                wr_ptr_d = wr_ptr_q + PTR_W'(1);
            end else begin
                wr_ptr_d = wr_ptr_q;
            end
            if (pop_s) begin
                rd_ptr_d = rd_ptr_q + PTR_W'(1);
            end else begin
                rd_ptr_d = rd_ptr_q;
            end
            case ({push_s, pop_s})
                2'b10:   cnt_d = cnt_q + CNT_W'(1);
                2'b01:   cnt_d = cnt_q - CNT_W'(1);
                default: cnt_d = cnt_q;
            endcase
        end
    end

    // Pointer and occupancy registers.
    always_ff @(posedge clk) begin
        if (rst) begin
            wr_ptr_q <= PTR_W'(0);
            rd_ptr_q <= PTR_W'(0);
            cnt_q    <= CNT_W'(0);
        end else begin
            wr_ptr_q <= wr_ptr_d;
            rd_ptr_q <= rd_ptr_d;
            cnt_q    <= cnt_d;
        end
    end

    // Entry storage; contents are unreachable after reset/flush so it needs no reset.
    always_ff @(posedge clk) begin
        if (push_s) begin
            pc_mem_q[wr_ptr_q]   <= bus.if_pc;
            inst_mem_q[wr_ptr_q] <= bus.if_inst;
        end
    end

    // Head presentation with zeroed bubble when empty.
    always_comb begin
        bus.if_ready = if_ready_s;
        bus.id_valid = id_valid_s;
        bus.count    = cnt_q;
        if (id_valid_s) begin
            bus.id_pc   = pc_mem_q[rd_ptr_q];
            bus.id_inst = inst_mem_q[rd_ptr_q];
        end else begin
            bus.id_pc   = ADDR_W'(ZeroWord);
            bus.id_inst = INST_W'(ZeroWord);
        end
    end

endmodule

// File: tb/tb_if_id_buffer.sv
// Directed bench for if_id_buffer: reset, single pass, full/backpressure,
// wrap with concurrent push/pop, flush collision and mid-run reset.
module tb_if_id_buffer;

    logic clk;
    logic rst;
    int   tests;
    int   failed;

    if_id_buffer_if #(.ADDR_W(32), .INST_W(32), .DEPTH(4)) bus ();

    if_id_buffer #(.ADDR_W(32), .INST_W(32), .DEPTH(4)) dut (
        .clk (clk),
        .rst (rst),
        .bus (bus)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        tests++;
        assert (obs === exp) else begin
            failed++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    task automatic chk_out(input string tag, input logic v, input logic [31:0] pc,
                           input logic [31:0] inst, input logic [2:0] cnt, input logic rdy);
        chk({tag, ".id_valid"}, {31'd0, bus.id_valid}, {31'd0, v});
        chk({tag, ".id_pc"},    bus.id_pc,             pc);
        chk({tag, ".id_inst"},  bus.id_inst,           inst);
        chk({tag, ".count"},    {29'd0, bus.count},    {29'd0, cnt});
        chk({tag, ".if_ready"}, {31'd0, bus.if_ready}, {31'd0, rdy});
    endtask

    // One clock edge; outputs are then observed 1 time unit later.
    task automatic step();
        @(posedge clk);
        #1;
    endtask

    initial begin
        tests  = 0;
        failed = 0;
        rst          = 1'b1;
        bus.flush    = 1'b0;
        bus.if_valid = 1'b1;
        bus.if_pc    = 32'h0000_0100;
        bus.if_inst  = 32'h0000_DEAD;
        bus.id_ready = 1'b0;

        // Reset held for two edges with a pending fetch.
        step();
        chk_out("rst_hold", 1'b0, 32'h0, 32'h0, 3'd0, 1'b1);
        step();
        rst          = 1'b0;
        bus.if_valid = 1'b0;
        #1;
        chk_out("rst_release", 1'b0, 32'h0, 32'h0, 3'd0, 1'b1);

        // Single entry pass.
        bus.if_valid = 1'b1;
        bus.if_pc    = 32'h0000_1000;
        bus.if_inst  = 32'h2402_0001;
        step();
        bus.if_valid = 1'b0;
        chk_out("single_push", 1'b1, 32'h0000_1000, 32'h2402_0001, 3'd1, 1'b1);
        bus.id_ready = 1'b1;
        step();
        bus.id_ready = 1'b0;
        chk_out("single_pop", 1'b0, 32'h0, 32'h0, 3'd0, 1'b1);

        // Fill to capacity with id_ready low.
        for (int i = 0; i < 4; i++) begin
            bus.if_valid = 1'b1;
            bus.if_pc    = 32'(4 * i);
            bus.if_inst  = 32'h0000_00A0 + 32'(i);
            step();
        end
        chk_out("fill", 1'b1, 32'h0, 32'h0000_00A0, 3'd4, 1'b0);
        bus.if_pc   = 32'h0000_0010;
        bus.if_inst = 32'h0000_00A4;
        step();
        chk_out("full_reject", 1'b1, 32'h0, 32'h0000_00A0, 3'd4, 1'b0);
        // Pop while full with if_valid still high: no push may slip in.
        bus.id_ready = 1'b1;
        step();
        bus.if_valid = 1'b0;
        bus.id_ready = 1'b0;
        chk_out("full_pop", 1'b1, 32'h0000_0004, 32'h0000_00A1, 3'd3, 1'b1);
        bus.id_ready = 1'b1;
        step();
        chk_out("drain1", 1'b1, 32'h0000_0008, 32'h0000_00A2, 3'd2, 1'b1);
        step();
        chk_out("drain2", 1'b1, 32'h0000_000C, 32'h0000_00A3, 3'd1, 1'b1);
        step();
        bus.id_ready = 1'b0;
        chk_out("drain3", 1'b0, 32'h0, 32'h0, 3'd0, 1'b1);

        // Streaming across pointer wrap: steady occupancy of one.
        bus.id_ready = 1'b1;
        for (int k = 0; k < 12; k++) begin
            bus.if_valid = 1'b1;
            bus.if_pc    = 32'(4 * k);
            bus.if_inst  = 32'h0000_0B00 + 32'(k);
            step();
            chk("stream.id_pc",   bus.id_pc,   32'(4 * k));
            chk("stream.id_inst", bus.id_inst, 32'h0000_0B00 + 32'(k));
            chk("stream.count",   {29'd0, bus.count}, 32'd1);
        end
        bus.if_valid = 1'b0;
        step();
        bus.id_ready = 1'b0;
        chk_out("stream_end", 1'b0, 32'h0, 32'h0, 3'd0, 1'b1);

        // Flush colliding with a push and a pop.
        for (int i = 0; i < 3; i++) begin
            bus.if_valid = 1'b1;
            bus.if_pc    = 32'h0000_0500 + 32'(4 * i);
            bus.if_inst  = 32'h0000_0C00 + 32'(i);
            step();
        end
        chk_out("pre_flush", 1'b1, 32'h0000_0500, 32'h0000_0C00, 3'd3, 1'b1);
        bus.flush    = 1'b1;
        bus.if_valid = 1'b1;
        bus.if_pc    = 32'h0000_0200;
        bus.if_inst  = 32'h0000_0D00;
        bus.id_ready = 1'b1;
        step();
        bus.flush    = 1'b0;
        bus.if_valid = 1'b0;
        bus.id_ready = 1'b0;
        chk_out("flush", 1'b0, 32'h0, 32'h0, 3'd0, 1'b1);
        bus.if_valid = 1'b1;
        bus.if_pc    = 32'h0000_0300;
        bus.if_inst  = 32'h0000_0E00;
        step();
        bus.if_valid = 1'b0;
        chk_out("post_flush", 1'b1, 32'h0000_0300, 32'h0000_0E00, 3'd1, 1'b1);
        bus.id_ready = 1'b1;
        step();
        bus.id_ready = 1'b0;
        chk_out("post_flush_pop", 1'b0, 32'h0, 32'h0, 3'd0, 1'b1);

        // Reset in the middle of operation with a concurrent push.
        for (int i = 0; i < 2; i++) begin
            bus.if_valid = 1'b1;
            bus.if_pc    = 32'h0000_0600 + 32'(4 * i);
            bus.if_inst  = 32'h0000_0F00 + 32'(i);
            step();
        end
        chk_out("pre_rst", 1'b1, 32'h0000_0600, 32'h0000_0F00, 3'd2, 1'b1);
        rst          = 1'b1;
        bus.if_pc    = 32'h0000_0700;
        bus.if_inst  = 32'h0000_0F10;
        step();
        rst          = 1'b0;
        bus.if_valid = 1'b0;
        chk_out("mid_rst", 1'b0, 32'h0, 32'h0, 3'd0, 1'b1);
        bus.if_valid = 1'b1;
        bus.if_pc    = 32'h0000_0800;
        bus.if_inst  = 32'h0000_0F20;
        step();
        bus.if_valid = 1'b0;
        chk_out("post_rst", 1'b1, 32'h0000_0800, 32'h0000_0F20, 3'd1, 1'b1);
        bus.id_ready = 1'b1;
        step();
        bus.id_ready = 1'b0;
        chk_out("post_rst_pop", 1'b0, 32'h0, 32'h0, 3'd0, 1'b1);

        $display("[TB] %0d tests run, %0d failed", tests, failed);
        $finish;
    end

endmodule
